prog_fetch_ctrl: RTL and testbench

//  Fetch sequencer and ROM arbiter that sits between the synchronous ProgRom and the MCU decoder.
//  It owns PROG_ADDR: it issues sequential fetches, handles stalls, jumps and the interrupt vector,
//  and lends single ROM read cycles to a debug/readback requester.
//  ROM contract: PROG_ADDR sampled at posedge t -> PROG_IR valid during cycle t+1.

---
 rtl/prog_fetch_ctrl.sv | 115 +++++++++++
 tb/tb_prog_fetch_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_fetch_ctrl.sv
// Fetch sequencer and ROM arbiter between ProgRom and the MCU decoder.
// Owns PROG_ADDR: sequential fetch, stall re-read, jump, interrupt vector and debug read steals.
module prog_fetch_ctrl #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 18,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] INTR_VEC  = '1,
    parameter int unsigned DBG_MAX_WAIT = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic [ADDR_W-1:0] PROG_ADDR,
    input  logic [DATA_W-1:0] PROG_IR,
    output logic [DATA_W-1:0] IR,
    output logic [ADDR_W-1:0] IR_PC,
    output logic              IR_VALID,
    input  logic              IR_READY,
    input  logic              JMP_EN,
    input  logic [ADDR_W-1:0] JMP_ADDR,
    input  logic              INTR_EN,
    input  logic              DBG_REQ,
    input  logic [ADDR_W-1:0] DBG_ADDR,
    output logic              DBG_GNT,
    output logic [DATA_W-1:0] DBG_DATA,
    output logic              DBG_VALID
);

    localparam int unsigned CNT_W = $clog2(DBG_MAX_WAIT + 1);

    typedef enum logic [1:0] {BOOT, FETCH, DBG} state_t;

    state_t            state;
    logic [ADDR_W-1:0] replay;
    logic [ADDR_W-1:0] ir_pc;
    logic [CNT_W-1:0]  starve_cnt;
    logic              intr_pend;

    logic              in_fetch;
    logic              intr_take;
    logic              ir_valid_c;
    logic              jmp_take;
    logic              stalled;
    logic              starved;
    logic              gnt;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] addr_c;

    always_comb begin
        in_fetch   = (state != DBG);
        intr_take  = in_fetch & RST_N & (INTR_EN | intr_pend);
        // An interrupt taken this cycle squashes the instruction currently on IR.
        ir_valid_c = (state == FETCH) & ~intr_take;
        jmp_take   = ir_valid_c & JMP_EN;
        stalled    = ir_valid_c & ~IR_READY;
        starved    = (starve_cnt == CNT_W'(DBG_MAX_WAIT));
        gnt        = in_fetch & RST_N & ~intr_take & ~jmp_take & DBG_REQ & (stalled | starved);
        pc_inc     = ir_pc + 1'b1;

        addr_c = replay;
        if (!RST_N)
            addr_c = RESET_VEC;
        else if (state == DBG)
            addr_c = replay;
        else if (intr_take)
            addr_c = INTR_VEC;
        else if (jmp_take)
            addr_c = JMP_ADDR;
        else if (gnt)
            addr_c = DBG_ADDR;
        else if (ir_valid_c & IR_READY)
            addr_c = pc_inc;
        else if (ir_valid_c)
            addr_c = ir_pc;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= BOOT;
            replay     <= RESET_VEC;
            ir_pc      <= RESET_VEC;
            intr_pend  <= 1'b0;
            starve_cnt <= '0;
        end else begin
            ir_pc <= addr_c;
            if (state == DBG) begin
                state     <= FETCH;
                intr_pend <= intr_pend | INTR_EN;
            end else begin
                intr_pend <= 1'b0;
                if (gnt) begin
                    state      <= DBG;
                    starve_cnt <= '0;
                    // Resume point after the steal: re-read a stalled IR, otherwise the next one.
                    if (ir_valid_c)
                        replay <= stalled ? ir_pc : pc_inc;
                end else begin
                    state <= FETCH;
                    if (!DBG_REQ)
                        starve_cnt <= '0;
                    else if (!starved)
                        starve_cnt <= starve_cnt + 1'b1;
                end
            end
        end
    end

    assign PROG_ADDR = addr_c;
    assign IR        = PROG_IR;
    assign IR_PC     = ir_pc;
    assign IR_VALID  = ir_valid_c;
    assign DBG_GNT   = gnt;
    assign DBG_VALID = (state == DBG);
    assign DBG_DATA  = (state == DBG) ? PROG_IR : '0;

endmodule

// File: tb/tb_prog_fetch_ctrl.sv
// Directed bench for prog_fetch_ctrl with a synchronous ROM model whose contents are a fixed
// function of the address.
module tb_prog_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [9:0]  PROG_ADDR;
    logic [17:0] PROG_IR;
    logic [17:0] IR;
    logic [9:0]  IR_PC;
    logic        IR_VALID;
    logic        IR_READY;
    logic        JMP_EN;
    logic [9:0]  JMP_ADDR;
    logic        INTR_EN;
    logic        DBG_REQ;
    logic [9:0]  DBG_ADDR;
    logic        DBG_GNT;
    logic [17:0] DBG_DATA;
    logic        DBG_VALID;

    int unsigned errors = 0;
    int unsigned checks = 0;

    prog_fetch_ctrl #(
        .ADDR_W(10), .DATA_W(18), .RESET_VEC(10'h000), .INTR_VEC(10'h3FF), .DBG_MAX_WAIT(8)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .PROG_ADDR(PROG_ADDR), .PROG_IR(PROG_IR), .IR(IR),
        .IR_PC(IR_PC), .IR_VALID(IR_VALID), .IR_READY(IR_READY), .JMP_EN(JMP_EN),
        .JMP_ADDR(JMP_ADDR), .INTR_EN(INTR_EN), .DBG_REQ(DBG_REQ), .DBG_ADDR(DBG_ADDR),
        .DBG_GNT(DBG_GNT), .DBG_DATA(DBG_DATA), .DBG_VALID(DBG_VALID)
    );

    always #5 CLK = ~CLK;

    function automatic logic [17:0] rom_f(input logic [9:0] a);
        return {a[7:0] ^ 8'h5A, a};
    endfunction

    always @(posedge CLK) PROG_IR <= rom_f(PROG_ADDR);

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic jump_to(input logic [9:0] a);
        IR_READY = 1'b1; JMP_EN = 1'b1; JMP_ADDR = a;
        tick();
        JMP_EN = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; IR_READY = 1'b0; JMP_EN = 1'b0; JMP_ADDR = '0;
        INTR_EN = 1'b0; DBG_REQ = 1'b0; DBG_ADDR = '0;
        repeat (2) @(posedge CLK);
        #3;
        checks++; if (IR_VALID !== 1'b0) begin errors++; $display("FAIL rst_ir_valid: got %b exp 0", IR_VALID); end
        checks++; if (DBG_GNT !== 1'b0) begin errors++; $display("FAIL rst_dbg_gnt: got %b exp 0", DBG_GNT); end
        checks++; if (DBG_VALID !== 1'b0) begin errors++; $display("FAIL rst_dbg_valid: got %b exp 0", DBG_VALID); end
        checks++; if (DBG_DATA !== 18'h0) begin errors++; $display("FAIL rst_dbg_data: got %h exp 0", DBG_DATA); end
        checks++; if (PROG_ADDR !== 10'h000) begin errors++; $display("FAIL rst_prog_addr: got %h exp 000", PROG_ADDR); end
    endtask

    task automatic test_sequential();
        tick();
        RST_N = 1'b1; IR_READY = 1'b1;
        #2;
        checks++; if (PROG_ADDR !== 10'h000) begin errors++; $display("FAIL boot_addr: got %h exp 000", PROG_ADDR); end
        checks++; if (IR_VALID !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b exp 0", IR_VALID); end
        tick();
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++; if (IR_VALID !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b exp 1", i, IR_VALID); end
            checks++; if (IR_PC !== 10'(i)) begin errors++; $display("FAIL seq_pc[%0d]: got %h exp %h", i, IR_PC, 10'(i)); end
            checks++; if (IR !== rom_f(10'(i))) begin errors++; $display("FAIL seq_ir[%0d]: got %h exp %h", i, IR, rom_f(10'(i))); end
            tick();
        end
    endtask

    task automatic test_jump();
        JMP_EN = 1'b1; JMP_ADDR = 10'h040;
        #2;
        checks++; if (IR_PC !== 10'h003) begin errors++; $display("FAIL jmp_src_pc: got %h exp 003", IR_PC); end
        checks++; if (PROG_ADDR !== 10'h040) begin errors++; $display("FAIL jmp_addr: got %h exp 040", PROG_ADDR); end
        tick();
        JMP_EN = 1'b0;
        #2;
        checks++; if (IR_VALID !== 1'b1 || IR_PC !== 10'h040) begin errors++; $display("FAIL jmp_tgt: got v=%b pc=%h exp v=1 pc=040", IR_VALID, IR_PC); end
        checks++; if (IR !== rom_f(10'h040)) begin errors++; $display("FAIL jmp_ir: got %h exp %h", IR, rom_f(10'h040)); end
        tick();
        #2;
        checks++; if (IR_VALID !== 1'b1 || IR_PC !== 10'h041) begin errors++; $display("FAIL jmp_next: got v=%b pc=%h exp v=1 pc=041", IR_VALID, IR_PC); end
        tick();
    endtask

    task automatic test_stall();
        jump_to(10'h005);
        IR_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++; if (IR_VALID !== 1'b1 || IR_PC !== 10'h005) begin errors++; $display("FAIL stall_pc[%0d]: got v=%b pc=%h exp v=1 pc=005", i, IR_VALID, IR_PC); end
            checks++; if (IR !== rom_f(10'h005)) begin errors++; $display("FAIL stall_ir[%0d]: got %h exp %h", i, IR, rom_f(10'h005)); end
            checks++; if (PROG_ADDR !== 10'h005) begin errors++; $display("FAIL stall_addr[%0d]: got %h exp 005", i, PROG_ADDR); end
            tick();
        end
        IR_READY = 1'b1;
        #2;
        checks++; if (IR_PC !== 10'h005 || PROG_ADDR !== 10'h006) begin errors++; $display("FAIL stall_release: got pc=%h addr=%h exp pc=005 addr=006", IR_PC, PROG_ADDR); end
        tick();
        #2;
        checks++; if (IR_PC !== 10'h006) begin errors++; $display("FAIL stall_after: got %h exp 006", IR_PC); end
        tick();
    endtask

    task automatic test_interrupt();
        jump_to(10'h010);
        INTR_EN = 1'b1;
        #2;
        checks++; if (IR_VALID !== 1'b0) begin errors++; $display("FAIL intr_squash: got %b exp 0", IR_VALID); end
        checks++; if (PROG_ADDR !== 10'h3FF) begin errors++; $display("FAIL intr_addr: got %h exp 3ff", PROG_ADDR); end
        tick();
        INTR_EN = 1'b0;
        #2;
        checks++; if (IR_VALID !== 1'b1 || IR_PC !== 10'h3FF) begin errors++; $display("FAIL intr_vec: got v=%b pc=%h exp v=1 pc=3ff", IR_VALID, IR_PC); end
        checks++; if (IR !== rom_f(10'h3FF)) begin errors++; $display("FAIL intr_ir: got %h exp %h", IR, rom_f(10'h3FF)); end
        tick();
        #2;
        checks++; if (IR_PC !== 10'h000) begin errors++; $display("FAIL intr_wrap: got %h exp 000", IR_PC); end
        tick();
    endtask

    task automatic test_debug_stall();
        jump_to(10'h020);
        IR_READY = 1'b0; DBG_REQ = 1'b1; DBG_ADDR = 10'h123;
        #2;
        checks++; if (DBG_GNT !== 1'b1 || PROG_ADDR !== 10'h123) begin errors++; $display("FAIL dbg_gnt: got g=%b addr=%h exp g=1 addr=123", DBG_GNT, PROG_ADDR); end
        tick();
        JMP_EN = 1'b1; JMP_ADDR = 10'h2AA;
        #2;
        checks++; if (DBG_VALID !== 1'b1 || DBG_DATA !== rom_f(10'h123)) begin errors++; $display("FAIL dbg_data: got v=%b d=%h exp v=1 d=%h", DBG_VALID, DBG_DATA, rom_f(10'h123)); end
        checks++; if (IR_VALID !== 1'b0 || DBG_GNT !== 1'b0) begin errors++; $display("FAIL dbg_bubble: got v=%b g=%b exp v=0 g=0", IR_VALID, DBG_GNT); end
        checks++; if (PROG_ADDR !== 10'h020) begin errors++; $display("FAIL dbg_replay: got %h exp 020", PROG_ADDR); end
        tick();
        JMP_EN = 1'b0; DBG_REQ = 1'b0; IR_READY = 1'b1;
        #2;
        checks++; if (IR_VALID !== 1'b1 || IR_PC !== 10'h020 || DBG_VALID !== 1'b0) begin errors++; $display("FAIL dbg_resume: got v=%b pc=%h dv=%b exp v=1 pc=020 dv=0", IR_VALID, IR_PC, DBG_VALID); end
        tick();
        #2;
        checks++; if (IR_PC !== 10'h021) begin errors++; $display("FAIL dbg_jmp_ignored: got %h exp 021", IR_PC); end
        tick();
    endtask

    task automatic test_intr_boundaries();
        IR_READY = 1'b0; DBG_REQ = 1'b1; DBG_ADDR = 10'h0AB;
        #2;
        checks++; if (DBG_GNT !== 1'b1) begin errors++; $display("FAIL idbg_gnt: got %b exp 1", DBG_GNT); end
        tick();
        INTR_EN = 1'b1;
        #2;
        checks++; if (DBG_VALID !== 1'b1 || PROG_ADDR !== 10'h022) begin errors++; $display("FAIL idbg_dbg: got dv=%b addr=%h exp dv=1 addr=022", DBG_VALID, PROG_ADDR); end
        tick();
        INTR_EN = 1'b0; DBG_REQ = 1'b0; IR_READY = 1'b1;
        #2;
        checks++; if (IR_VALID !== 1'b0 || PROG_ADDR !== 10'h3FF) begin errors++; $display("FAIL idbg_pend: got v=%b addr=%h exp v=0 addr=3ff", IR_VALID, PROG_ADDR); end
        tick();
        #2;
        checks++; if (IR_VALID !== 1'b1 || IR_PC !== 10'h3FF) begin errors++; $display("FAIL idbg_vec: got v=%b pc=%h exp v=1 pc=3ff", IR_VALID, IR_PC); end
        tick();
        IR_READY = 1'b0; DBG_REQ = 1'b1; DBG_ADDR = 10'h055; INTR_EN = 1'b1;
        #2;
        checks++; if (DBG_GNT !== 1'b0 || PROG_ADDR !== 10'h3FF) begin errors++; $display("FAIL igrant_prio: got g=%b addr=%h exp g=0 addr=3ff", DBG_GNT, PROG_ADDR); end
        tick();
        INTR_EN = 1'b0;
        #2;
        checks++; if (DBG_GNT !== 1'b1 || PROG_ADDR !== 10'h055) begin errors++; $display("FAIL igrant_late: got g=%b addr=%h exp g=1 addr=055", DBG_GNT, PROG_ADDR); end
        tick();
        #2;
        checks++; if (DBG_DATA !== rom_f(10'h055) || PROG_ADDR !== 10'h3FF) begin errors++; $display("FAIL igrant_dbg: got d=%h addr=%h exp d=%h addr=3ff", DBG_DATA, PROG_ADDR, rom_f(10'h055)); end
        tick();
        DBG_REQ = 1'b0; IR_READY = 1'b1;
        #2;
        checks++; if (IR_VALID !== 1'b1 || IR_PC !== 10'h3FF) begin errors++; $display("FAIL igrant_resume: got v=%b pc=%h exp v=1 pc=3ff", IR_VALID, IR_PC); end
        tick();
    endtask

    task automatic test_starvation();
        IR_READY = 1'b1; DBG_REQ = 1'b1; DBG_ADDR = 10'h0F0;
        for (int i = 0; i < 8; i++) begin
            #2;
            checks++; if (DBG_GNT !== 1'b0 || IR_PC !== 10'(i)) begin errors++; $display("FAIL starve_wait[%0d]: got g=%b pc=%h exp g=0 pc=%h", i, DBG_GNT, IR_PC, 10'(i)); end
            tick();
        end
        #2;
        checks++; if (DBG_GNT !== 1'b1 || PROG_ADDR !== 10'h0F0 || IR_PC !== 10'h008) begin errors++; $display("FAIL starve_gnt: got g=%b addr=%h pc=%h exp g=1 addr=0f0 pc=008", DBG_GNT, PROG_ADDR, IR_PC); end
        tick();
        #2;
        checks++; if (IR_VALID !== 1'b0 || DBG_DATA !== rom_f(10'h0F0) || PROG_ADDR !== 10'h009) begin errors++; $display("FAIL starve_dbg: got v=%b d=%h addr=%h exp v=0 d=%h addr=009", IR_VALID, DBG_DATA, PROG_ADDR, rom_f(10'h0F0)); end
        tick();
        DBG_REQ = 1'b0;
        #2;
        checks++; if (IR_VALID !== 1'b1 || IR_PC !== 10'h009) begin errors++; $display("FAIL starve_next: got v=%b pc=%h exp v=1 pc=009", IR_VALID, IR_PC); end
        tick();
    endtask

    task automatic test_reset_in_dbg();
        IR_READY = 1'b0; DBG_REQ = 1'b1; DBG_ADDR = 10'h100;
        #2;
        checks++; if (DBG_GNT !== 1'b1 || IR_PC !== 10'h00A) begin errors++; $display("FAIL rdbg_gnt: got g=%b pc=%h exp g=1 pc=00a", DBG_GNT, IR_PC); end
        tick();
        RST_N = 1'b0;
        #2;
        checks++; if (DBG_VALID !== 1'b0 || DBG_DATA !== 18'h0) begin errors++; $display("FAIL rdbg_drop: got dv=%b d=%h exp dv=0 d=0", DBG_VALID, DBG_DATA); end
        checks++; if (IR_VALID !== 1'b0 || PROG_ADDR !== 10'h000) begin errors++; $display("FAIL rdbg_state: got v=%b addr=%h exp v=0 addr=000", IR_VALID, PROG_ADDR); end
        DBG_REQ = 1'b0; IR_READY = 1'b1;
        tick();
        RST_N = 1'b1;
        #2;
        checks++; if (IR_VALID !== 1'b0 || PROG_ADDR !== 10'h000 || DBG_VALID !== 1'b0) begin errors++; $display("FAIL rdbg_boot: got v=%b addr=%h dv=%b exp v=0 addr=000 dv=0", IR_VALID, PROG_ADDR, DBG_VALID); end
        tick();
        #2;
        checks++; if (IR_VALID !== 1'b1 || IR_PC !== 10'h000 || IR !== rom_f(10'h000)) begin errors++; $display("FAIL rdbg_restart: got v=%b pc=%h ir=%h exp v=1 pc=000 ir=%h", IR_VALID, IR_PC, IR, rom_f(10'h000)); end
        tick();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_stall();
        test_interrupt();
        test_debug_stall();
        test_intr_boundaries();
        test_starvation();
        test_reset_in_dbg();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
